state_period_meter: RTL

- Downstream consumer of the threshold discriminator's 1-bit `state_out`.
- Measures the clock-cycle interval between consecutive accepted rising edges of the discriminator state (the signal period) and streams each measurement out on an AXI4-Stream master.
- Keeps an accepted-edge counter and sticky saturation and overrun flags for PS readback.
- Runs in the 125 MHz ADC clock domain.

---
 rtl/state_period_meter_if.sv | 21 ++
 rtl/state_period_meter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/state_period_meter_if.sv
// Stream bundle carrying measured periods out of the meter.
// Master drives tdata/tvalid; slave drives tready.
interface state_period_meter_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/state_period_meter.sv
// Period meter on the discriminator state: streams the cycle count
// between accepted rising edges, with edge counter and sticky flags.
module state_period_meter #(
  parameter int CNT_WIDTH        = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MIN_PERIOD       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 state_in,
  input  logic                 enable,
  state_period_meter_if.master M_AXIS_OUT,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 saturated,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] HOLDOFF =
    CNT_WIDTH'(MIN_PERIOD);

  state_e state_q;

  logic s_q;
  logic s_dly_q;
  logic en_q;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] edges_q;
  logic [CNT_WIDTH-1:0] edges_d;

  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                        tvalid_q;
  logic                        sat_q;
  logic                        ovr_q;

  logic rise;
  logic arm_acc;
  logic meas_acc;
  logic accept;
  logic xfer;
  logic load;
  logic drop;

  assign rise = s_q & ~s_dly_q;

  assign arm_acc = enable & rise
                 & (state_q == ARM);

  assign meas_acc = enable & rise
                  & (state_q == MEAS)
                  & (cnt_q >= HOLDOFF);

  assign accept = arm_acc | meas_acc;

  assign xfer = tvalid_q & M_AXIS_OUT.tready;

  // A stalled full register drops the word
  // but the edge still restarts the period.
  assign load = meas_acc
              & (~tvalid_q | M_AXIS_OUT.tready);
  assign drop = meas_acc & tvalid_q
              & ~M_AXIS_OUT.tready;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || state_q == IDLE) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    edges_d = edges_q;
    if (enable && !en_q) begin
      edges_d = '0;
    end else if (accept) begin
      edges_d = edges_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      s_dly_q  <= 1'b0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      edges_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s_q     <= state_in;
      s_dly_q <= s_q;
      en_q    <= enable;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;

      if (!enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (rise) state_q <= MEAS;
          end
          MEAS:    state_q <= MEAS;
          default: state_q <= IDLE;
        endcase
      end

      if (load) begin
        tdata_q  <= AXIS_TDATA_WIDTH'(cnt_q);
        tvalid_q <= 1'b1;
        if (cnt_q == CNT_MAX) sat_q <= 1'b1;
      end else if (xfer) begin
        tvalid_q <= 1'b0;
      end

      if (drop) ovr_q <= 1'b1;
    end
  end

  assign M_AXIS_OUT.tdata  = tdata_q;
  assign M_AXIS_OUT.tvalid = tvalid_q;
  assign edge_count        = edges_q;
  assign saturated         = sat_q;
  assign overrun           = ovr_q;

endmodule
